alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Parametrised, registered successor of the combinational 32-bit ALU: executes ARM-style data-processing ops on
//  WIDTH-bit operands and returns the result plus N/Z/C/V flags. Sits between decode and writeback in the Pac-ARM
//  core; valid/ready handshake on both sides. Optional multi-cycle multiplier.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=8, power of two)
//  SHW     $clog2(WIDTH)  shift-amount width (derived localparam, not overridable)
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operation presented
//  in_ready   out  1      block can accept operation this cycle
//  op         in   4      alu_pkg::alu_op_e opcode
//  dato_a     in   WIDTH  operand A
//  dato_b     in   WIDTH  operand B (shift amount = dato_b[SHW-1:0])
//  carry_in   in   1      incoming C flag
//  out_valid  out  1      result register holds valid result
//  out_ready  in   1      consumer takes result this cycle
//  salida     out  WIDTH  result
//  flag_n/flag_z/flag_c/flag_v  out 1 each  flags of salida
//  illegal    out  1      op was undefined (or MUL with multiplier compiled out)
// BEHAVIOUR
//  Reset: out_valid=0, salida=0, all flags=0, illegal=0, FSM=IDLE; any in-flight multiply is discarded.
//  Handshake: transfer on in_valid&&in_ready; result retired on out_valid&&out_ready. in_ready =
//   (state==IDLE) && (!out_valid || out_ready). Outputs are stable while out_valid&&!out_ready.
//  Latency: single-cycle ops -> out_valid one cycle after acceptance; back-to-back throughput 1/cycle.
//  Opcodes: ADD=0 a+b; ADC=1 a+b+cin; SUB=2 a-b (a+~b+1); SBC=3 a+~b+cin; AND=4; ORR=5; EOR=6; BIC=7 a&~b;
//   LSL=8; LSR=9; ASR=10; MOV=11 b; MVN=12 ~b; MUL=13 low WIDTH bits of a*b; 14,15 illegal.
//  Flags: N=salida[WIDTH-1]; Z=(salida==0). Arithmetic: C=carry out of WIDTH-bit add (SUB: C=1 means no borrow);
//   V=(a_msb==b'_msb)&&(res_msb!=a_msb), b' = operand actually added. Logical/MOV/MVN: C=cin, V=0.
//   Shifts: amount 0 -> salida=a, C=cin; else C=last bit shifted out; V=0. MUL: C=cin, V=0.
//  Illegal op: salida=0, N=0, Z=1, C=cin, V=0, illegal=1; one-cycle latency like any other op.
//  FSM: IDLE -> (accept MUL) -> MUL_BUSY; MUL_BUSY counts WIDTH cycles of shift-add, then loads result register,
//   out_valid=1, -> IDLE. Multiply latency = WIDTH+1 cycles from acceptance. in_ready=0 throughout MUL_BUSY.
//  MUL entry requires the result register to be free (guaranteed by in_ready); MUL never overwrites an unconsumed result.
//  Simultaneous retire+accept: the old result leaves and the new one loads in the same edge; no bubble.
//  Reset mid-multiply: asynchronous clear, partial product and counter discarded, no output produced.
// CONFIGURATION
//  ALU_PIPE_MUL_EN defined: MUL implemented as above (iterative, one adder, WIDTH cycles).
//  Not defined: no MUL_BUSY state, no multiplier registers; op 13 treated as illegal (illegal=1, 1-cycle latency).
// STRUCTURE
//  alu_pkg: alu_op_e enum (4-bit, values above), alu_flags_t struct {n,z,c,v}, alu_state_e {IDLE, MUL_BUSY}.
//  Sub-module adder_nbit #(WIDTH): a, b, cin -> sum, cout; instanced once for ADD/ADC/SUB/SBC (b pre-inverted),
//   and reused by the multiplier accumulator when ALU_PIPE_MUL_EN is defined.
// TESTING
//  ADD 0xFFFFFFFF+0x00000001 -> salida=0, Z=1, C=1, V=0, N=0, out_valid one cycle after accept.
//  SUB 0x80000000-0x00000001 -> 0x7FFFFFFF, V=1, C=1, N=0; SUB 0x00000003-0x00000005 -> 0xFFFFFFFE, C=0, N=1.
//  ASR 0x80000000 by 4 -> 0xF8000000, C=0; LSL 0x80000001 by 1 -> 0x00000002, C=1; LSR by 0 with cin=1 -> a, C=1.
//  Backpressure: out_ready=0 for 3 cycles with second op pending -> in_ready=0, salida/flags held; out_ready=1 ->
//   first retires and second loads same edge.
//  MUL 7*6 (MUL_EN) -> 42 after WIDTH+1 cycles, in_ready low meanwhile; rst_n pulse at cycle 10 -> out_valid stays 0.
//  Without MUL_EN: op 13 and op 15 -> salida=0, Z=1, illegal=1, next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
//------------------------------------------------------------------------------
// Module   : alu_pkg
// Purpose  : Shared opcode, flag and FSM state types for the pipelined ALU.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  typedef enum logic [3:0] {
    ADD   = 4'd0,
    ADC   = 4'd1,
    SUB   = 4'd2,
    SBC   = 4'd3,
    AND   = 4'd4,
    ORR   = 4'd5,
    EOR   = 4'd6,
    BIC   = 4'd7,
    LSL   = 4'd8,
    LSR   = 4'd9,
    ASR   = 4'd10,
    MOV   = 4'd11,
    MVN   = 4'd12,
    MUL   = 4'd13,
    ILL14 = 4'd14,
    ILL15 = 4'd15
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } alu_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_pipe_adder.sv
//------------------------------------------------------------------------------
// Module   : adder_nbit
// Purpose  : WIDTH-bit ripple adder with carry in/out, shared by ALU and multiplier.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module adder_nbit #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

`default_nettype wire

// File: rtl/alu_pipe.sv
//------------------------------------------------------------------------------
// Module   : alu_pipe
// Purpose  : Registered ARM-style ALU with valid/ready on both sides and N/Z/C/V
//            flags. Define ALU_PIPE_MUL_EN to build the iterative shift-add MUL.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] dato_a,
  input  logic [WIDTH-1:0] dato_b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] salida,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  alu_op_e          w_op;
  logic             w_accept;
  logic             w_loadAlu;
  logic [WIDTH-1:0] w_addA;
  logic [WIDTH-1:0] w_addB;
  logic             w_addCin;
  logic [WIDTH-1:0] w_sum;
  logic             w_addCout;
  logic [SHW-1:0]   w_shAmt;
  logic [WIDTH:0]   w_lslWide;
  logic [WIDTH:0]   w_lsrWide;
  logic [WIDTH:0]   w_asrWide;
  logic [WIDTH-1:0] w_res;
  alu_flags_t       w_flags;
  logic             w_illegal;

  logic             r_outValid;
  logic [WIDTH-1:0] r_salida;
  alu_flags_t       r_flags;
  logic             r_illegal;

  assign w_op     = alu_op_e'(op);
  assign w_accept = in_valid && in_ready;
  assign w_shAmt  = dato_b[SHW-1:0];

  // Extra bit on each shift catches the last bit shifted out.
  assign w_lslWide = {1'b0, dato_a} << w_shAmt;
  assign w_lsrWide = {dato_a, 1'b0} >> w_shAmt;
  assign w_asrWide = $signed({dato_a, 1'b0}) >>> w_shAmt;

`ifdef ALU_PIPE_MUL_EN
  alu_state_e       r_state;
  alu_state_e       w_stateNext;
  logic             w_mulDone;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [SHW-1:0]   r_mulCnt;
  logic             r_mulCin;

  assign in_ready  = (r_state == IDLE) && (!r_outValid || out_ready);
  assign w_loadAlu = w_accept && (w_op != MUL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    w_mulDone   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && (w_op == MUL)) w_stateNext = MUL_BUSY;
      end
      MUL_BUSY: begin
        if (r_mulCnt == SHW'(WIDTH - 1)) begin
          w_mulDone   = 1'b1;
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_mulCnt <= '0;
      r_mulCin <= 1'b0;
    end else if (w_accept && (w_op == MUL)) begin
      r_mcand  <= dato_a;
      r_mplier <= dato_b;
      r_acc    <= '0;
      r_mulCnt <= '0;
      r_mulCin <= carry_in;
    end else if (r_state == MUL_BUSY) begin
      r_acc    <= w_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_mulCnt <= r_mulCnt + SHW'(1);
    end
  end
`else
  assign in_ready  = !r_outValid || out_ready;
  assign w_loadAlu = w_accept;
`endif

  // The single adder serves the ALU ops and, while busy, the multiply accumulator.
  always_comb begin
    w_addA   = dato_a;
    w_addB   = ((w_op == SUB) || (w_op == SBC)) ? ~dato_b : dato_b;
    case (w_op)
      ADC, SBC: w_addCin = carry_in;
      SUB:      w_addCin = 1'b1;
      default:  w_addCin = 1'b0;
    endcase
`ifdef ALU_PIPE_MUL_EN
    if (r_state == MUL_BUSY) begin
      w_addA   = r_acc;
      w_addB   = r_mplier[0] ? r_mcand : '0;
      w_addCin = 1'b0;
    end
`endif
  end

  adder_nbit #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (w_addA),
    .b    (w_addB),
    .cin  (w_addCin),
    .sum  (w_sum),
    .cout (w_addCout)
  );

  always_comb begin
    w_res     = '0;
    w_flags   = '{n: 1'b0, z: 1'b0, c: carry_in, v: 1'b0};
    w_illegal = 1'b0;
    case (w_op)
      ADD, ADC, SUB, SBC: begin
        w_res     = w_sum;
        w_flags.c = w_addCout;
        w_flags.v = (dato_a[MSB] == w_addB[MSB]) && (w_sum[MSB] != dato_a[MSB]);
      end
      AND: w_res = dato_a & dato_b;
      ORR: w_res = dato_a | dato_b;
      EOR: w_res = dato_a ^ dato_b;
      BIC: w_res = dato_a & ~dato_b;
      LSL: begin
        w_res = dato_a;
        if (w_shAmt != '0) {w_flags.c, w_res} = w_lslWide;
      end
      LSR: begin
        w_res = dato_a;
        if (w_shAmt != '0) {w_res, w_flags.c} = w_lsrWide;
      end
      ASR: begin
        w_res = dato_a;
        if (w_shAmt != '0) {w_res, w_flags.c} = w_asrWide;
      end
      MOV: w_res = dato_b;
      MVN: w_res = ~dato_b;
`ifdef ALU_PIPE_MUL_EN
      MUL: w_res = '0;
`endif
      default: w_illegal = 1'b1;
    endcase
    w_flags.n = w_res[MSB];
    w_flags.z = (w_res == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_salida   <= '0;
      r_flags    <= '0;
      r_illegal  <= 1'b0;
    end else if (w_loadAlu) begin
      r_outValid <= 1'b1;
      r_salida   <= w_res;
      r_flags    <= w_flags;
      r_illegal  <= w_illegal;
`ifdef ALU_PIPE_MUL_EN
    end else if (w_mulDone) begin
      r_outValid <= 1'b1;
      r_salida   <= w_sum;
      r_flags    <= '{n: w_sum[MSB], z: (w_sum == '0), c: r_mulCin, v: 1'b0};
      r_illegal  <= 1'b0;
`endif
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign out_valid = r_outValid;
  assign salida    = r_salida;
  assign flag_n    = r_flags.n;
  assign flag_z    = r_flags.z;
  assign flag_c    = r_flags.c;
  assign flag_v    = r_flags.v;
  assign illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_pipe
// Purpose  : Scoreboard bench for alu_pipe; honours ALU_PIPE_MUL_EN when defined.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_pipe;

  localparam int W = 32;
`ifdef ALU_PIPE_MUL_EN
  localparam bit MULEN = 1'b1;
`else
  localparam bit MULEN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] dato_a;
  logic [W-1:0] dato_b;
  logic         carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] salida;
  logic         flag_n, flag_z, flag_c, flag_v;
  logic         illegal;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .dato_a(dato_a), .dato_b(dato_b), .carry_in(carry_in), .out_valid(out_valid),
    .out_ready(out_ready), .salida(salida), .flag_n(flag_n), .flag_z(flag_z),
    .flag_c(flag_c), .flag_v(flag_v), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         n, z, c, v, ill;
    int           acc;
    int           lat;
    string        name;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   orMode   = 1;  // 0: stall, 1: always ready, 2: random

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input logic cin);
    exp_t         e;
    logic [63:0]  ua, ub, ur;
    longint       sa, sb, sr;
    int           n;
    bit           arith;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = $signed(a);
    sb = $signed(b);
    n  = int'(b[4:0]);
    e.res = '0; e.c = cin; e.v = 1'b0; e.ill = 1'b0;
    arith = 1'b0; sr = 0;
    case (o)
      4'd0: begin ur = ua + ub;        e.res = ur[31:0]; e.c = (ur >= 64'h1_0000_0000); sr = sa + sb; arith = 1; end
      4'd1: begin ur = ua + ub + cin;  e.res = ur[31:0]; e.c = (ur >= 64'h1_0000_0000); sr = sa + sb + cin; arith = 1; end
      4'd2: begin e.res = a - b;       e.c = (ua >= ub); sr = sa - sb; arith = 1; end
      4'd3: begin e.res = a - b - 32'(!cin); e.c = (ua + cin >= ub + 1); sr = sa - sb - 1 + cin; arith = 1; end
      4'd4: e.res = a & b;
      4'd5: e.res = a | b;
      4'd6: e.res = a ^ b;
      4'd7: e.res = a & ~b;
      4'd8: begin e.res = a << n; if (n != 0) e.c = a[32-n]; end
      4'd9: begin e.res = a >> n; if (n != 0) e.c = a[n-1]; end
      4'd10: begin e.res = $signed(a) >>> n; if (n != 0) e.c = a[n-1]; end
      4'd11: e.res = b;
      4'd12: e.res = ~b;
      4'd13: begin
        if (MULEN) begin ur = ua * ub; e.res = ur[31:0]; end
        else e.ill = 1'b1;
      end
      default: e.ill = 1'b1;
    endcase
    if (arith) e.v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    e.n = e.res[31];
    e.z = (e.res == 0);
    e.lat = (o == 4'd13 && MULEN) ? W + 1 : 1;
    return e;
  endfunction

  task automatic driveReady();
    case (orMode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom % 2);
    endcase
  endtask

  task automatic issue(input string nm, input logic [3:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ci);
    exp_t e;
    int   tries = 0;
    e = model(o, a, b, ci);
    e.name = nm;
    forever begin
      @(negedge clk);
      in_valid = 1'b1; op = o; dato_a = a; dato_b = b; carry_in = ci;
      driveReady();
      #1;
      if (in_ready) begin
        e.acc = cyc;
        q.push_back(e);
        break;
      end
      tries++;
      if (tries > 200) begin
        checks++; failures++;
        $display("FAIL %s_accept_timeout in_ready=0 required=1 within 200 cycles", nm);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      driveReady();
    end
  endtask

  task automatic drain();
    int n = 0;
    orMode = 1;
    while (q.size() != 0 && n < 300) begin
      idle(1);
      n++;
    end
    if (q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout pending=%0d required=0", q.size());
      q.delete();
    end
    idle(1);
  endtask

  task automatic checkResetState(input string nm);
    check({nm, "_out_valid"}, out_valid, 0);
    check({nm, "_salida"}, salida, 0);
    check({nm, "_flags"}, {flag_n, flag_z, flag_c, flag_v}, 0);
    check({nm, "_illegal"}, illegal, 0);
  endtask

  // Monitor: compares each retired result against the head of the scoreboard.
  initial begin : monitor
    bit           seen;
    bit           stalled;
    logic [W-1:0] hs;
    logic [4:0]   hf;
    exp_t         e;
    seen = 0; stalled = 0; hs = '0; hf = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        seen = 0; stalled = 0;
      end else if (out_valid) begin
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL spurious_output salida=%0h required=no output", salida);
        end else begin
          e = q[0];
          if (!seen) begin
            check({e.name, "_latency"}, 64'(cyc - e.acc), 64'(e.lat));
            seen = 1;
          end
          if (stalled) begin
            check({e.name, "_hold"}, {salida, flag_n, flag_z, flag_c, flag_v, illegal}, {hs, hf});
          end
          if (out_ready) begin
            check({e.name, "_salida"}, salida, e.res);
            check({e.name, "_nzcv"}, {flag_n, flag_z, flag_c, flag_v}, {e.n, e.z, e.c, e.v});
            check({e.name, "_illegal"}, illegal, e.ill);
            void'(q.pop_front());
            seen = 0; stalled = 0;
          end else begin
            stalled = 1;
            hs = salida;
            hf = {flag_n, flag_z, flag_c, flag_v, illegal};
          end
        end
      end else begin
        stalled = 0;
      end
    end
  end

  initial begin : driver
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; op = '0; dato_a = '0; dato_b = '0;
    carry_in = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst_n = 1'b1;

    orMode = 1;
    issue("add_wrap",  4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    issue("sub_ovf",   4'd2,  32'h8000_0000, 32'h0000_0001, 1'b0);
    issue("sub_borrow",4'd2,  32'h0000_0003, 32'h0000_0005, 1'b0);
    issue("asr4",      4'd10, 32'h8000_0000, 32'h0000_0004, 1'b1);
    issue("lsl1",      4'd8,  32'h8000_0001, 32'h0000_0001, 1'b0);
    issue("lsr0",      4'd9,  32'h1234_5678, 32'h0000_0000, 1'b1);
    issue("adc",       4'd1,  32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
    issue("sbc",       4'd3,  32'h0000_0005, 32'h0000_0005, 1'b0);
    issue("ill15",     4'd15, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);
    issue("op13",      4'd13, 32'h0000_0007, 32'h0000_0006, 1'b0);
`ifdef ALU_PIPE_MUL_EN
    repeat (W) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1 check("mul_busy_in_ready", in_ready, 0);
    end
`endif
    issue("ill14",     4'd14, 32'h0000_0001, 32'h0000_0002, 1'b0);
    drain();

    // Backpressure: first result stalls while a second op waits.
    orMode = 0;
    issue("bp1", 4'd6, 32'hA5A5_0F0F, 32'h0F0F_A5A5, 1'b1);
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1; op = 4'd11; dato_a = '0; dato_b = 32'hCAFE_F00D; carry_in = 1'b0;
      out_ready = 1'b0;
      #1 check("bp_in_ready", in_ready, 0);
    end
    orMode = 1;
    issue("bp2", 4'd11, 32'h0, 32'hCAFE_F00D, 1'b0);
    drain();

`ifdef ALU_PIPE_MUL_EN
    issue("mul_rst", 4'd13, 32'h0000_0007, 32'h0000_0006, 1'b0);
    idle(9);
    @(negedge clk);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    q.delete();
    #1 checkResetState("midmul_reset");
    #2 rst_n = 1'b1;
    repeat (W + 5) begin
      @(negedge clk);
      #1 check("midmul_no_output", out_valid, 0);
    end
`endif

    orMode = 2;
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom % 6)
        0: ra = 32'h8000_0000;
        1: rb = 32'hFFFF_FFFF;
        2: rb = rb & 32'h1F;
        default: ;
      endcase
      issue("rand", 4'($urandom % 16), ra, rb, 1'($urandom % 2));
      if ($urandom % 4 == 0) idle(1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
